// File: rtl/id_pipe_if.sv
// rtl/id_pipe_if.sv - fetch/writeback/hazard/execute signal bundle for the decode stage
interface id_pipe_if #(
  parameter int XLEN = 32
);
  // fetch side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  // register-file write port
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  // load-use hazard information from EX, and branch flush
  logic            ex_is_load;
  logic [4:0]      ex_rd;
  logic            flush;
  // execute side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_r1;
  logic [XLEN-1:0] out_r2;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic [6:0]      out_opcode;
  logic [2:0]      out_f3;
  logic [6:0]      out_f7;
  logic            out_illegal;

  // the decode stage
  modport slave (
    input  in_valid, inst, pc, wb_en, wb_rd, wb_data, ex_is_load, ex_rd, flush, out_ready,
    output in_ready, out_valid, out_pc, out_r1, out_r2, out_imm, out_rd, out_opcode,
           out_f3, out_f7, out_illegal
  );

  // the surrounding pipeline
  modport master (
    output in_valid, inst, pc, wb_en, wb_rd, wb_data, ex_is_load, ex_rd, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_r1, out_r2, out_imm, out_rd, out_opcode,
           out_f3, out_f7, out_illegal
  );
endinterface

// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - RV decode stage: register file, immediate generation, load-use stall, one output register
module id_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  id_pipe_if.slave bus
);

  localparam int              RW      = $clog2(NREGS);
  localparam logic [5:0]      NREGS_L = 6'(NREGS);

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  // instruction fields
  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = bus.inst[6:0];
  assign rd     = bus.inst[11:7];
  assign f3     = bus.inst[14:12];
  assign rs1    = bus.inst[19:15];
  assign rs2    = bus.inst[24:20];
  assign f7     = bus.inst[31:25];

  fmt_e fmt;
  logic rs1_used, rs2_used;

  // classify the opcode into an encoding format
  always_comb begin
    fmt = FMT_BAD;
    case (opcode)
      7'h33:                      fmt = FMT_R;
      7'h13, 7'h03, 7'h67, 7'h73: fmt = FMT_I;
      7'h23:                      fmt = FMT_S;
      7'h63:                      fmt = FMT_B;
      7'h37, 7'h17:               fmt = FMT_U;
      7'h6F:                      fmt = FMT_J;
      default:                    fmt = FMT_BAD;
    endcase
  end

  // illegal opcodes read no source, so they never cause a load-use stall
  assign rs1_used = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  assign rs2_used = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm_x;

  // assemble the 32-bit sign-extended immediate for each format
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
      FMT_S:   imm32 = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
      FMT_B:   imm32 = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7], bus.inst[30:25],
                        bus.inst[11:8], 1'b0};
      FMT_U:   imm32 = {bus.inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12], bus.inst[20],
                        bus.inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // widen to XLEN keeping the sign
  assign imm_x = XLEN'(imm32);

  // register file; x0 is never written so it stays at its reset value of zero
  logic [XLEN-1:0] rf_q [NREGS];
  logic            wb_hit;
  logic [RW-1:0]   wb_idx;

  assign wb_hit = bus.wb_en && (bus.wb_rd != 5'd0) && ({1'b0, bus.wb_rd} < NREGS_L);
  assign wb_idx = bus.wb_rd[RW-1:0];

  // write port, and clearing of every register during reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_hit) begin
      rf_q[wb_idx] <= bus.wb_data;
    end
  end

  logic [XLEN-1:0] r1_val, r2_val;

  // source 1 read with optional same-cycle writeback forwarding
  always_comb begin
    r1_val = '0;
    if ((rs1 != 5'd0) && ({1'b0, rs1} < NREGS_L)) begin
      if ((BYPASS != 0) && wb_hit && (bus.wb_rd == rs1)) begin
        r1_val = bus.wb_data;
      end else begin
        r1_val = rf_q[rs1[RW-1:0]];
      end
    end
  end

  // source 2 read with optional same-cycle writeback forwarding
  always_comb begin
    r2_val = '0;
    if ((rs2 != 5'd0) && ({1'b0, rs2} < NREGS_L)) begin
      if ((BYPASS != 0) && wb_hit && (bus.wb_rd == rs2)) begin
        r2_val = bus.wb_data;
      end else begin
        r2_val = rf_q[rs2[RW-1:0]];
      end
    end
  end

  // output stage state
  logic            valid_q,   valid_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [XLEN-1:0] r1_q,      r1_d;
  logic [XLEN-1:0] r2_q,      r2_d;
  logic [XLEN-1:0] imm_q,     imm_d;
  logic [4:0]      rd_q,      rd_d;
  logic [6:0]      opcode_q,  opcode_d;
  logic [2:0]      f3_q,      f3_d;
  logic [6:0]      f7_q,      f7_d;
  logic            illegal_q, illegal_d;

  logic stall, in_ready, accept;

  // a load in EX whose result this instruction needs must wait one cycle
  assign stall = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                 (((bus.ex_rd == rs1) && rs1_used) || ((bus.ex_rd == rs2) && rs2_used));

  // reset gates in_ready so nothing is taken while the stage is being cleared
  assign in_ready = rst_n && (!valid_q || bus.out_ready) && !stall && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  // next state of the output stage: flush empties it, a free slot takes the
  // new instruction or a bubble, otherwise everything holds
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    opcode_d  = opcode_q;
    f3_d      = f3_q;
    f7_d      = f7_q;
    illegal_d = illegal_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (!valid_q || bus.out_ready) begin
      valid_d = accept;
      if (accept) begin
        pc_d      = bus.pc;
        r1_d      = r1_val;
        r2_d      = r2_val;
        opcode_d  = opcode;
        f3_d      = f3;
        f7_d      = f7;
        illegal_d = (fmt == FMT_BAD);
        imm_d     = (fmt == FMT_BAD) ? '0 : imm_x;
        rd_d      = (fmt == FMT_BAD) ? 5'd0 : rd;
      end
    end
  end

  // output stage register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      opcode_q  <= '0;
      f3_q      <= '0;
      f7_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      opcode_q  <= opcode_d;
      f3_q      <= f3_d;
      f7_q      <= f7_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_r1      = r1_q;
  assign bus.out_r2      = r2_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_opcode  = opcode_q;
  assign bus.out_f3      = f3_q;
  assign bus.out_f7      = f7_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - self-checking bench for id_pipe with a behavioural decode model
module tb_id_pipe;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int BYPASS = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_pipe_if #(.XLEN(XLEN)) bus ();

  id_pipe #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [6:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            ill;
  } exp_t;

  exp_t            e = '0;
  logic [XLEN-1:0] mregs [32];
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
  endfunction

  function automatic bit uses_rs1(input logic [6:0] op);
    return is_legal(op) && !(op inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic bit uses_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  // immediate rebuilt with signed 64-bit arithmetic on the whole word
  function automatic logic [XLEN-1:0] model_imm(input logic [31:0] i);
    longint s, v;
    s = longint'($signed(i));
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: v = s >>> 20;
      7'h23: v = ((s >>> 25) <<< 5) | longint'(i[11:7]);
      7'h63: v = ((s >>> 31) <<< 12) | (longint'(i[7]) <<< 11) |
                 (longint'(i[30:25]) <<< 5) | (longint'(i[11:8]) <<< 1);
      7'h37, 7'h17: v = s & ~longint'(12'hFFF);
      7'h6F: v = ((s >>> 31) <<< 20) | (longint'(i[19:12]) <<< 12) |
                 (longint'(i[20]) <<< 11) | (longint'(i[30:21]) <<< 1);
      default: v = 0;
    endcase
    return v[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] mread(input logic [4:0] rs);
    if (rs == 0 || rs >= NREGS) return '0;
    if (BYPASS != 0 && bus.wb_en && bus.wb_rd == rs) return bus.wb_data;
    return mregs[rs];
  endfunction

  function automatic exp_t mdecode(input logic [31:0] i, input logic [XLEN-1:0] pc);
    exp_t x;
    x       = '0;
    x.valid = 1'b1;
    x.pc    = pc;
    x.op    = i[6:0];
    x.f3    = i[14:12];
    x.f7    = i[31:25];
    x.r1    = mread(i[19:15]);
    x.r2    = mread(i[24:20]);
    x.ill   = !is_legal(i[6:0]);
    x.rd    = x.ill ? 5'd0 : i[11:7];
    x.imm   = model_imm(i);
    return x;
  endfunction

  function automatic bit mstall();
    logic [31:0] i;
    i = bus.inst;
    return bus.ex_is_load && bus.ex_rd != 0 &&
           ((bus.ex_rd == i[19:15] && uses_rs1(i[6:0])) ||
            (bus.ex_rd == i[24:20] && uses_rs2(i[6:0])));
  endfunction

  function automatic bit model_ready();
    if (!rst_n) return 1'b0;
    return (!e.valid || bus.out_ready) && !mstall() && !bus.flush;
  endfunction

  task automatic model_update(input bit rdy);
    if (!rst_n) begin
      e = '0;
      for (int k = 0; k < 32; k++) mregs[k] = '0;
    end else begin
      if (bus.flush) e.valid = 1'b0;
      else if (!e.valid || bus.out_ready) begin
        if (bus.in_valid && rdy) e = mdecode(bus.inst, bus.pc);
        else e.valid = 1'b0;
      end
      if (bus.wb_en && bus.wb_rd != 0 && bus.wb_rd < NREGS) mregs[bus.wb_rd] = bus.wb_data;
    end
  endtask

  task automatic compare_out();
    check("out_valid", bus.out_valid, e.valid);
    if (e.valid) begin
      check("out_pc", bus.out_pc, e.pc);
      check("out_r1", bus.out_r1, e.r1);
      check("out_r2", bus.out_r2, e.r2);
      check("out_imm", bus.out_imm, e.imm);
      check("out_rd", bus.out_rd, e.rd);
      check("out_opcode", bus.out_opcode, e.op);
      check("out_f3", bus.out_f3, e.f3);
      check("out_f7", bus.out_f7, e.f7);
      check("out_illegal", bus.out_illegal, e.ill);
    end
  endtask

  // one clock: check in_ready for the driven inputs, advance the model, check outputs
  task automatic step();
    bit rdy;
    #1;
    rdy = model_ready();
    check("in_ready", bus.in_ready, rdy);
    @(posedge clk);
    model_update(rdy);
    @(negedge clk);
    compare_out();
  endtask

  task automatic idle();
    rst_n          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.inst       = '0;
    bus.pc         = '0;
    bus.wb_en      = 1'b0;
    bus.wb_rd      = '0;
    bus.wb_data    = '0;
    bus.ex_is_load = 1'b0;
    bus.ex_rd      = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [XLEN-1:0] d);
    bus.wb_en = 1'b1; bus.wb_rd = r; bus.wb_data = d;
    step();
    bus.wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] i, input logic [XLEN-1:0] p);
    bus.in_valid = 1'b1; bus.inst = i; bus.pc = p;
    step();
    bus.in_valid = 1'b0;
  endtask

  logic [6:0] op_tbl [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h7F};

  initial begin
    logic [31:0] ri;
    idle();
    rst_n = 1'b0;
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_rd", bus.out_rd, 0);
    check("rst_out_imm", bus.out_imm, 0);
    check("rst_out_r1", bus.out_r1, 0);
    check("rst_out_illegal", bus.out_illegal, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    #1 check("post_rst_in_ready", bus.in_ready, 1);

    // addi x18, x18, 0x135
    wb(5'd18, 32'h10);
    issue(32'h13590913, 32'h1000);
    check("addi_op", bus.out_opcode, 7'h13);
    check("addi_rd", bus.out_rd, 18);
    check("addi_r1", bus.out_r1, 32'h10);
    check("addi_f3", bus.out_f3, 0);
    check("addi_imm", bus.out_imm, 32'h135);

    // sw x24, 4(x5)
    wb(5'd5, 32'h100);
    wb(5'd24, 32'hDEAD);
    issue(32'h0182a223, 32'h1004);
    check("sw_op", bus.out_opcode, 7'h23);
    check("sw_f3", bus.out_f3, 2);
    check("sw_r1", bus.out_r1, 32'h100);
    check("sw_r2", bus.out_r2, 32'hDEAD);
    check("sw_imm", bus.out_imm, 4);

    // add x18, x9, x8 with a simultaneous write to x9
    wb(5'd9, 32'h3);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h7;
    issue(32'h00848933, 32'h1008);
    bus.wb_en = 1'b0;
    check("bypass_r1", bus.out_r1, (BYPASS != 0) ? 32'h7 : 32'h3);
    check("add_imm", bus.out_imm, 0);
    check("add_f7", bus.out_f7, 0);

    // load-use stall on rs2 = x8
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd8;
    bus.in_valid = 1'b1; bus.inst = 32'h00848933; bus.pc = 32'h100C;
    #1 check("stall_in_ready", bus.in_ready, 0);
    step();
    check("stall_bubble", bus.out_valid, 0);
    bus.ex_is_load = 1'b0;
    step();
    bus.in_valid = 1'b0;
    check("after_stall_valid", bus.out_valid, 1);
    check("after_stall_rd", bus.out_rd, 18);

    // backpressure for 3 cycles, with a writeback to a latched source, then flush
    issue(32'h0182a223, 32'h1010);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.inst = 32'h13590913; bus.pc = 32'h1014;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd24; bus.wb_data = 32'hBEEF;
    for (int k = 0; k < 3; k++) begin
      step();
      bus.wb_en = 1'b0;
      check("hold_valid", bus.out_valid, 1);
      check("hold_r2", bus.out_r2, 32'hDEAD);
      check("hold_imm", bus.out_imm, 4);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.flush = 1'b1;
    #1 check("flush_in_ready", bus.in_ready, 0);
    step();
    check("flush_valid", bus.out_valid, 0);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;

    // illegal opcodes and writes to x0
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h55;
    issue(32'h0000007F, 32'h1018);
    bus.wb_en = 1'b0;
    check("ill_flag", bus.out_illegal, 1);
    check("ill_imm", bus.out_imm, 0);
    issue(32'hFFFFFFFF, 32'h101C);
    check("ill2_rd", bus.out_rd, 0);
    check("ill2_imm", bus.out_imm, 0);
    issue(32'h00000093, 32'h1020);
    check("x0_read", bus.out_r1, 0);
    check("x0_legal", bus.out_illegal, 0);

    // reset while an instruction is held
    bus.out_ready = 1'b0;
    issue(32'h13590913, 32'h1024);
    rst_n = 1'b0;
    step();
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1; bus.out_ready = 1'b1;
    #1 check("midrst_ready_back", bus.in_ready, 1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      ri = $urandom;
      ri[6:0] = op_tbl[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) ri[6:0] = 7'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        ri[19:15] = 5'($urandom_range(0, 7));
        ri[24:20] = 5'($urandom_range(0, 7));
      end
      bus.inst       = ri;
      bus.pc         = XLEN'($urandom);
      bus.in_valid   = ($urandom_range(0, 9) < 7);
      bus.out_ready  = ($urandom_range(0, 9) < 7);
      bus.wb_en      = ($urandom_range(0, 1) == 1);
      bus.wb_rd      = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      bus.wb_data    = XLEN'($urandom);
      bus.ex_is_load = ($urandom_range(0, 3) == 0);
      bus.ex_rd      = 5'($urandom_range(0, 7));
      bus.flush      = ($urandom_range(0, 19) == 0);
      rst_n          = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/register width (32 or 64).
REQ-002 SHALL have parameter NREGS, default 32, architectural register count (16 or 32).
REQ-003 SHALL have parameter BYPASS, default 1, 1 = same-cycle writeback-to-read forwarding.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-007 inst / pc  in / in  32 / XLEN  instruction word and its PC.
REQ-008 wb_en / wb_rd / wb_data  in  1 / 5 / XLEN  register-file write port.
REQ-009 ex_is_load / ex_rd  in  1 / 5  instruction currently in EX is a load, and its destination.
REQ-010 flush  in  1  discard the held instruction (branch taken).
REQ-011 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-012 out_pc, out_r1, out_r2, out_imm  out  XLEN each  decoded operands.
REQ-013 out_rd, out_opcode, out_f3, out_f7, out_illegal  out  5, 7, 3, 7, 1  decoded fields.

Function
REQ-014 SHALL hold an NREGS x XLEN register file; x0 SHALL always read 0; writes to x0 or to rd >= NREGS SHALL be ignored.
REQ-015 SHALL perform the write on the rising clk edge when wb_en=1.
REQ-016 With BYPASS=1, a read of rs != 0 that matches wb_rd with wb_en=1 SHALL return wb_data in the same cycle; with BYPASS=0, the read SHALL return the pre-write value.
REQ-017 SHALL extract rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7], f3=inst[14:12], f7=inst[31:25], opcode=inst[6:0].
REQ-018 SHALL sign-extend the immediate to XLEN for I (0x13, 0x03, 0x67, 0x73), S (0x23), B (0x63), U (0x37, 0x17) and J (0x6F) formats; for R (0x33) the immediate SHALL be 0.
REQ-019 Any other opcode SHALL set out_illegal=1, with out_imm=0 and out_rd=0.
REQ-020 SHALL use a single output register stage: latency of 1 cycle from accept to out_valid.
REQ-021 Accept SHALL occur when in_valid and in_ready are both 1.
REQ-022 in_ready SHALL be (!out_valid | out_ready) & !stall & !flush.
REQ-023 stall SHALL be ex_is_load & (ex_rd != 0) & ((ex_rd == rs1 & rs1 used) | (ex_rd == rs2 & rs2 used)). rs1 is used by all formats except U/J; rs2 is used by R/S/B only.
REQ-024 During a stall, when the output is consumed (out_ready=1) or empty, the stage SHALL load a bubble: out_valid=0 on the next cycle.
REQ-025 With out_valid=1 and out_ready=0, all out_* SHALL hold stable, as SHALL the register values already latched.
REQ-026 flush=1 SHALL clear out_valid on the next cycle and block accept in that cycle; flush SHALL take priority over accept and stall.
REQ-027 A writeback to a register already latched in the output stage SHALL NOT update out_r1/out_r2. The execute stage forwards in that case.

Reset
REQ-028 While rst_n=0 at a clk edge: out_valid=0, and all out_* fields and out_illegal SHALL be 0.
REQ-029 While rst_n=0 at a clk edge, all registers SHALL be 0 and in_ready SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL drop the held instruction; in_ready SHALL return to 1 on the first cycle after rst_n=1.

Verification
REQ-031 Seed x18=0x10 by writeback, then issue inst=0x13590913 -> next cycle: out_opcode=0x13, out_rd=18, out_r1=0x10, out_f3=0, out_imm=0x135.
REQ-032 Issue inst=0x0182a223 with x5=0x100 and x24=0xDEAD -> out_opcode=0x23, out_f3=2, out_r1=0x100, out_r2=0xDEAD, out_imm=4.
REQ-033 Issue inst=0x00848933 in the same cycle as wb_en=1, wb_rd=9, wb_data=7 -> out_r1=7 with BYPASS=1; out_r1 = old x9 with BYPASS=0; out_imm=0, out_f7=0.
REQ-034 Set ex_is_load=1, ex_rd=8 and issue 0x00848933 -> in_ready=0 and one bubble; after ex_is_load=0, the instruction is accepted with 1-cycle latency.
REQ-035 Hold out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0; assert flush -> out_valid=0 on the next cycle.
REQ-036 Issue inst=0x0000007F and a write to x0 with data 0x55 -> out_illegal=1, and a later read of x0 returns 0.
